// File: rtl/pe_outcha_single_serializer_pkg.sv
// Shared PE parameters: default word width and channel count for the PE
// datapath blocks, plus the serializer's two-state control encoding.
// No ports; imported by the PE blocks with import pe_outcha_single_serializer_pkg::*.
package pe_outcha_single_serializer_pkg;

  localparam int PE_DATA_WIDTH = 16;
  localparam int PE_IN_CHANNEL = 16;

  // IDLE: nothing held, o_valid low. BUSY: a vector is being emitted.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ser_state_e;

endpackage

// File: rtl/pe_outcha_single_serializer.sv
// Purpose: parallel vector -> serial channel words, channel 0 first.
// Latency: channel 0 valid one cycle after the vector is accepted; back-to-back vectors with no bubble.
// Backpressure: words hold stable while i_ready=0; o_ready only rises when idle or the last word leaves.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   i_data/i_valid/o_ready parallel input vector handshake (channel k at bits [(k+1)*DW-1 : k*DW])
//   o_data/o_valid/o_last  serial output word, o_last marks channel IN_CHANNEL-1
//   i_ready                downstream accepts o_data
module pe_outcha_single_serializer
  import pe_outcha_single_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int IN_CHANNEL = PE_IN_CHANNEL
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH*IN_CHANNEL-1:0] i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  output logic                             o_last,
  input  logic                             i_ready
);

  localparam int CNT_W = $clog2(IN_CHANNEL);
  localparam logic [CNT_W-1:0] LAST_CHA = CNT_W'(IN_CHANNEL - 1);

  ser_state_e            state_q;
  ser_state_e            state_d;
  logic [CNT_W-1:0]      cha_cnt;
  logic [DATA_WIDTH-1:0] sbuf [IN_CHANNEL];
  logic                  accept;
  logic                  xfer;

  // o_valid is the state flop itself, so it is registered and drops the
  // moment reset asserts. o_last is a pure decode of flops.
  assign o_valid = (state_q == ST_BUSY);
  assign o_last  = o_valid && (cha_cnt == LAST_CHA);
  assign o_data  = sbuf[0];

  // A new vector may only enter when the buffer is empty or its final word
  // is leaving this very cycle; this keeps back-to-back vectors gapless.
  assign o_ready = !rst && (!o_valid || (o_last && i_ready));

  assign accept = i_valid && o_ready;
  assign xfer   = o_valid && i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Stay busy when a fresh vector replaces the one finishing now.
        if (xfer && o_last && !accept) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Channel index of the word currently at the head of the shift buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cha_cnt <= '0;
    end else if (accept) begin
      cha_cnt <= '0;
    end else if (xfer) begin
      cha_cnt <= (cha_cnt == LAST_CHA) ? '0 : cha_cnt + CNT_W'(1);
    end
  end

  // Data registers are intentionally not reset: o_data is only meaningful
  // while o_valid is high, and every vector fully reloads the buffer.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < IN_CHANNEL; k++) begin
        sbuf[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (xfer) begin
      for (int k = 0; k < IN_CHANNEL - 1; k++) begin
        sbuf[k] <= sbuf[k+1];
      end
    end
  end

endmodule
